// File: rtl/alu_op_sequencer.sv
// Request/response front-end for the serial-operand ALU: replays (op, A, B) on the
// start/s/inbus protocol, captures one or two result words, and aborts hung operations.
module alu_op_sequencer #(
  parameter int W       = 16,
  parameter int TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         rst_b,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [1:0]   req_op,
  input  logic [W-1:0] req_a,
  input  logic [W-1:0] req_b,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_hi,
  output logic [W-1:0] rsp_lo,
  output logic [3:0]   rsp_flags,
  output logic         rsp_timeout,
  output logic         alu_start,
  output logic [1:0]   alu_s,
  output logic [W-1:0] alu_inbus,
  input  logic [W-1:0] alu_outbus,
  input  logic         alu_finish,
  input  logic [3:0]   alu_flags,
  output logic         alu_clr
);

  localparam int WDW = $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_HOLD, S_OPB, S_WAIT, S_CAP2, S_RESP
  } state_t;

  state_t         state_q, state_d;
  logic [1:0]     op_q, op_d;
  logic [W-1:0]   b_q, b_d;
  logic [WDW-1:0] wd_q, wd_d;
  logic           req_ready_q, req_ready_d;
  logic           alu_start_q, alu_start_d;
  logic [1:0]     alu_s_q, alu_s_d;
  logic [W-1:0]   alu_inbus_q, alu_inbus_d;
  logic           alu_clr_q, alu_clr_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic [W-1:0]   rsp_hi_q, rsp_hi_d;
  logic [W-1:0]   rsp_lo_q, rsp_lo_d;
  logic [3:0]     rsp_flags_q, rsp_flags_d;
  logic           rsp_timeout_q, rsp_timeout_d;

  // Outputs are computed together with the next state so they line up with it.
  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    b_d           = b_q;
    wd_d          = wd_q;
    req_ready_d   = req_ready_q;
    alu_start_d   = 1'b0;
    alu_s_d       = alu_s_q;
    alu_inbus_d   = alu_inbus_q;
    alu_clr_d     = 1'b0;
    rsp_valid_d   = rsp_valid_q;
    rsp_hi_d      = rsp_hi_q;
    rsp_lo_d      = rsp_lo_q;
    rsp_flags_d   = rsp_flags_q;
    rsp_timeout_d = rsp_timeout_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready_q) begin
          op_d        = req_op;
          b_d         = req_b;
          wd_d        = '0;
          req_ready_d = 1'b0;
          alu_start_d = 1'b1;
          alu_s_d     = req_op;
          alu_inbus_d = req_a;
          state_d     = S_START;
        end
      end
      S_START: state_d = S_HOLD;
      S_HOLD: begin
        alu_inbus_d = b_q;
        state_d     = S_OPB;
      end
      S_OPB: state_d = S_WAIT;
      S_WAIT: begin
        // A result arriving on the last watchdog cycle still beats the abort.
        if (alu_finish) begin
          rsp_flags_d = alu_flags;
          alu_inbus_d = '0;
          if (!op_q[1]) begin
            rsp_lo_d    = alu_outbus;
            rsp_hi_d    = '0;
            rsp_valid_d = 1'b1;
            state_d     = S_RESP;
          end else begin
            rsp_hi_d = alu_outbus;
            state_d  = S_CAP2;
          end
        end else if (wd_q == WDW'(TIMEOUT - 1)) begin
          rsp_hi_d      = '0;
          rsp_lo_d      = '0;
          rsp_flags_d   = '0;
          rsp_timeout_d = 1'b1;
          rsp_valid_d   = 1'b1;
          alu_clr_d     = 1'b1;
          alu_inbus_d   = '0;
          state_d       = S_RESP;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      S_CAP2: begin
        rsp_lo_d    = alu_outbus;
        rsp_valid_d = 1'b1;
        state_d     = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d   = 1'b0;
          rsp_timeout_d = 1'b0;
          alu_s_d       = 2'b00;
          req_ready_d   = 1'b1;
          state_d       = S_IDLE;
        end
      end
      default: begin
        alu_inbus_d = '0;
        alu_s_d     = 2'b00;
        req_ready_d = 1'b1;
        rsp_valid_d = 1'b0;
        state_d     = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_b) begin
      state_q       <= S_IDLE;
      op_q          <= 2'b00;
      b_q           <= '0;
      wd_q          <= '0;
      req_ready_q   <= 1'b1;
      alu_start_q   <= 1'b0;
      alu_s_q       <= 2'b00;
      alu_inbus_q   <= '0;
      alu_clr_q     <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_hi_q      <= '0;
      rsp_lo_q      <= '0;
      rsp_flags_q   <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      b_q           <= b_d;
      wd_q          <= wd_d;
      req_ready_q   <= req_ready_d;
      alu_start_q   <= alu_start_d;
      alu_s_q       <= alu_s_d;
      alu_inbus_q   <= alu_inbus_d;
      alu_clr_q     <= alu_clr_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_hi_q      <= rsp_hi_d;
      rsp_lo_q      <= rsp_lo_d;
      rsp_flags_q   <= rsp_flags_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign alu_start   = alu_start_q;
  assign alu_s       = alu_s_q;
  assign alu_inbus   = alu_inbus_q;
  assign alu_clr     = alu_clr_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_hi      = rsp_hi_q;
  assign rsp_lo      = rsp_lo_q;
  assign rsp_flags   = rsp_flags_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural ALU stub that finishes on
// the eighth WAIT cycle and returns two words for mul/div.
module tb_alu_op_sequencer;

  localparam int W = 16;
  localparam int T = 64;

  logic         clk = 1'b0;
  logic         rst_b = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [1:0]   req_op = 2'b00;
  logic [W-1:0] req_a = '0;
  logic [W-1:0] req_b = '0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic [W-1:0] rsp_hi, rsp_lo;
  logic [3:0]   rsp_flags;
  logic         rsp_timeout;
  logic         alu_start;
  logic [1:0]   alu_s;
  logic [W-1:0] alu_inbus;
  logic [W-1:0] alu_outbus;
  logic         alu_finish;
  logic [3:0]   alu_flags;
  logic         alu_clr;

  int n_checks = 0;
  int n_errors = 0;
  int clr_cnt  = 0;

  alu_op_sequencer #(.W(W), .TIMEOUT(T)) dut (
    .clk(clk), .rst_b(rst_b),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_hi(rsp_hi), .rsp_lo(rsp_lo),
    .rsp_flags(rsp_flags), .rsp_timeout(rsp_timeout),
    .alu_start(alu_start), .alu_s(alu_s), .alu_inbus(alu_inbus),
    .alu_outbus(alu_outbus), .alu_finish(alu_finish), .alu_flags(alu_flags),
    .alu_clr(alu_clr)
  );

  always #5 clk = ~clk;

  // ALU stub: start seen -> cnt=1; B sampled when cnt==2; finish at cnt==10 (8th WAIT cycle).
  int           stub_cnt  = 0;
  logic         stub_hang = 1'b0;
  logic [1:0]   stub_op   = 2'b00;
  logic [W-1:0] stub_a    = '0;
  logic [W-1:0] stub_b    = '0;
  logic [W-1:0] stub_hi, stub_lo;
  logic [3:0]   stub_fl;

  always @(posedge clk) begin
    if (alu_start) begin
      stub_cnt <= 1;
      stub_op  <= alu_s;
      stub_a   <= alu_inbus;
    end else if (stub_cnt != 0 && stub_cnt < 20) begin
      stub_cnt <= stub_cnt + 1;
    end
    if (stub_cnt == 2) stub_b <= alu_inbus;
    if (alu_clr) clr_cnt <= clr_cnt + 1;
  end

  always_comb begin
    logic [W:0]     sum;
    logic [2*W-1:0] prod;
    stub_hi = '0;
    stub_lo = '0;
    stub_fl = '0;
    sum     = '0;
    prod    = '0;
    case (stub_op)
      2'b00: begin
        sum     = {1'b0, stub_a} + {1'b0, stub_b};
        stub_lo = sum[W-1:0];
        stub_fl = {stub_lo[W-1], stub_lo == '0, sum[W],
                   (stub_a[W-1] == stub_b[W-1]) && (stub_lo[W-1] != stub_a[W-1])};
      end
      2'b01: begin
        stub_lo = stub_a - stub_b;
        stub_fl = {stub_lo[W-1], stub_lo == '0, stub_a < stub_b,
                   (stub_a[W-1] != stub_b[W-1]) && (stub_lo[W-1] != stub_a[W-1])};
      end
      2'b10: begin
        prod    = stub_a * stub_b;
        stub_hi = prod[2*W-1:W];
        stub_lo = prod[W-1:0];
        stub_fl = {stub_hi[W-1], prod == '0, 2'b00};
      end
      default: begin
        if (stub_a != '0) begin
          stub_lo = stub_b / stub_a;
          stub_hi = stub_b % stub_a;
        end
        stub_fl = {stub_hi[W-1], {stub_hi, stub_lo} == '0, 2'b00};
      end
    endcase
  end

  assign alu_finish = !stub_hang && (stub_cnt == 10);
  assign alu_outbus = (stub_cnt == 10) ? (stub_op[1] ? stub_hi : stub_lo) :
                      (stub_cnt == 11) ? stub_lo : '0;
  assign alu_flags  = (stub_cnt == 10) ? stub_fl : 4'h0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_req(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    check("req_ready_before", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_op    = 2'b00;
    req_a     = '0;
    req_b     = '0;
    check("start_pulse", {31'd0, alu_start}, 32'd1);
    check("start_s", {30'd0, alu_s}, {30'd0, op});
    check("start_inbus_a", {16'd0, alu_inbus}, {16'd0, a});
    check("req_ready_busy", {31'd0, req_ready}, 32'd0);
  endtask

  // Waits for rsp_valid, checking the HOLD/OPB bus phases and the edge count.
  task automatic wait_rsp(input int exp_lat, input logic [W-1:0] a, input logic [W-1:0] b);
    int cyc = 0;
    while (cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc == 1) begin
        check("hold_start_low", {31'd0, alu_start}, 32'd0);
        check("hold_inbus_a", {16'd0, alu_inbus}, {16'd0, a});
      end
      if (cyc == 2) check("opb_inbus_b", {16'd0, alu_inbus}, {16'd0, b});
      if (rsp_valid) break;
    end
    check("rsp_latency", cyc, exp_lat);
  endtask

  task automatic check_rsp(input logic [W-1:0] hi, input logic [W-1:0] lo,
                           input logic [3:0] fl, input logic to);
    check("rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check("rsp_hi", {16'd0, rsp_hi}, {16'd0, hi});
    check("rsp_lo", {16'd0, rsp_lo}, {16'd0, lo});
    check("rsp_flags", {28'd0, rsp_flags}, {28'd0, fl});
    check("rsp_timeout", {31'd0, rsp_timeout}, {31'd0, to});
    check("resp_inbus_zero", {16'd0, alu_inbus}, 32'd0);
  endtask

  task automatic release_rsp();
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    check("rel_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rel_req_ready", {31'd0, req_ready}, 32'd1);
    check("rel_timeout_clr", {31'd0, rsp_timeout}, 32'd0);
    check("rel_alu_s_zero", {30'd0, alu_s}, 32'd0);
  endtask

  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] hi, input logic [W-1:0] lo, input logic [3:0] fl);
    send_req(op, a, b);
    wait_rsp(op[1] ? 12 : 11, a, b);
    check_rsp(hi, lo, fl, 1'b0);
    release_rsp();
  endtask

  initial begin
    int seen;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_alu_start", {31'd0, alu_start}, 32'd0);
    check("rst_alu_clr", {31'd0, alu_clr}, 32'd0);
    check("rst_alu_inbus", {16'd0, alu_inbus}, 32'd0);
    check("rst_rsp_word", {rsp_hi, rsp_lo}, 32'd0);
    check("rst_timeout", {31'd0, rsp_timeout}, 32'd0);
    @(negedge clk);
    rst_b = 1'b0;

    run_op(2'b00, 16'd2147, 16'd5, 16'd0, 16'd2152, 4'b0000);
    run_op(2'b01, 16'd5, 16'd7, 16'd0, 16'hFFFE, 4'b1010);
    run_op(2'b00, 16'hFFFF, 16'h0001, 16'd0, 16'h0000, 4'b0110);
    run_op(2'b00, 16'h7FFF, 16'h0001, 16'd0, 16'h8000, 4'b1001);
    run_op(2'b10, 16'd2350, 16'd159, 16'h0005, 16'hB392, 4'b0000);
    run_op(2'b11, 16'd145, 16'd18921, 16'd71, 16'd130, 4'b0000);

    // Watchdog abort.
    stub_hang = 1'b1;
    send_req(2'b10, 16'd3, 16'd4);
    wait_rsp(3 + T, 16'd3, 16'd4);
    check_rsp(16'd0, 16'd0, 4'd0, 1'b1);
    check("clr_pulse_on", {31'd0, alu_clr}, 32'd1);
    @(posedge clk);
    #1;
    check("clr_pulse_off", {31'd0, alu_clr}, 32'd0);
    check("timeout_held", {31'd0, rsp_timeout}, 32'd1);
    release_rsp();
    check("clr_pulse_count", clr_cnt, 32'd1);
    stub_hang = 1'b0;

    // Backpressure: response held, new requests refused.
    send_req(2'b00, 16'd100, 16'd23);
    wait_rsp(11, 16'd100, 16'd23);
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = 2'b11;
    req_a     = 16'd9;
    req_b     = 16'd99;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("stall_req_ready", {31'd0, req_ready}, 32'd0);
      check("stall_rsp", {rsp_valid, 15'd0, rsp_lo}, {1'b1, 15'd0, 16'd123});
    end
    @(negedge clk);
    req_valid = 1'b0;
    check_rsp(16'd0, 16'd123, 4'b0000, 1'b0);
    release_rsp();
    run_op(2'b01, 16'd1000, 16'd1, 16'd0, 16'd999, 4'b0000);

    // Reset while waiting on the ALU.
    send_req(2'b00, 16'd11, 16'd22);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_b = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_req_ready", {31'd0, req_ready}, 32'd1);
    check("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("midrst_alu_start", {31'd0, alu_start}, 32'd0);
    check("midrst_inbus", {16'd0, alu_inbus}, 32'd0);
    @(negedge clk);
    rst_b = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (rsp_valid || alu_start) seen++;
    end
    check("midrst_no_rsp", seen, 32'd0);
    run_op(2'b00, 16'd2147, 16'd5, 16'd0, 16'd2152, 4'b0000);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout obs=running exp=finished");
    $fatal(1);
  end

endmodule
